// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue sequencer: opcodes,
// flag bit positions, instruction field layout and sequencer states.
package alu_pkg;

  localparam int NUM_OPS = 10;
  localparam int DATA_W  = 16;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_CMP  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_NOT  = 5'd6,
    OP_LSH  = 5'd7,
    OP_RSH  = 5'd8,
    OP_ARSH = 5'd9
  } opcode_e;

  // Flag vector layout is {C, L, F, Z, N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Instruction word: [15:11] opcode, [10:7] dest, [6:3] src, [2:0] unused
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int DST_MSB = 10;
  localparam int DST_LSB = 7;
  localparam int SRC_MSB = 6;
  localparam int SRC_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE
  } seq_state_e;

  function automatic logic [4:0] instrOpcode(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [3:0] instrDest(input logic [15:0] word);
    return word[DST_MSB:DST_LSB];
  endfunction

  function automatic logic [3:0] instrSrc(input logic [15:0] word);
    return word[SRC_MSB:SRC_LSB];
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: Out = Rdest op Rsrc. ADD/SUB report carry/borrow and
// signed overflow; CMP reports equality and unsigned/signed less-than.
module ALU
  import alu_pkg::*;
(
  input  logic [15:0] Rsrc,
  input  logic [15:0] Rdest,
  input  logic [4:0]  OpCode,
  output logic [15:0] Out,
  output logic [4:0]  Flags
);

  logic [16:0] wide;

  // Result and flag generation, all flags zero unless the opcode defines them
  always_comb begin
    Out   = '0;
    Flags = '0;
    wide  = '0;
    case (OpCode)
      OP_ADD: begin
        wide          = {1'b0, Rdest} + {1'b0, Rsrc};
        Out           = wide[15:0];
        Flags[FLAG_C] = wide[16];
        Flags[FLAG_F] = (Rdest[15] == Rsrc[15]) && (wide[15] != Rdest[15]);
      end
      OP_SUB: begin
        wide          = {1'b0, Rdest} - {1'b0, Rsrc};
        Out           = wide[15:0];
        Flags[FLAG_C] = wide[16];
        Flags[FLAG_F] = (Rdest[15] != Rsrc[15]) && (wide[15] != Rdest[15]);
      end
      OP_CMP: begin
        Out           = Rdest - Rsrc;
        Flags[FLAG_Z] = (Rdest == Rsrc);
        Flags[FLAG_L] = (Rdest < Rsrc);
        Flags[FLAG_N] = ($signed(Rdest) < $signed(Rsrc));
      end
      OP_AND:  Out = Rdest & Rsrc;
      OP_OR:   Out = Rdest | Rsrc;
      OP_XOR:  Out = Rdest ^ Rsrc;
      OP_NOT:  Out = ~Rsrc;
      OP_LSH:  Out = Rdest << Rsrc[3:0];
      OP_RSH:  Out = Rdest >> Rsrc[3:0];
      OP_ARSH: Out = $signed(Rdest) >>> Rsrc[3:0];
      default: Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer_regfile16.sv
// 16 x 16-bit register file: one write port, two operand read ports and a
// debug read port, all reads combinational.
module regfile16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [3:0]  raddrA_i,
  output logic [15:0] rdataA_o,
  input  logic [3:0]  raddrB_i,
  output logic [15:0] rdataB_o,
  input  logic [3:0]  dbgAddr_i,
  output logic [15:0] dbgData_o
);

  logic [15:0] mem_q [16];

  // Storage: cleared on reset, single write per clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdataA_o  = mem_q[raddrA_i];
  assign rdataB_o  = mem_q[raddrB_i];
  assign dbgData_o = mem_q[dbgAddr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state issue controller for the ALU: accept an instruction, read its
// operands, execute, then write back the result and/or latch the flags.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int NUM_OPS = alu_pkg::NUM_OPS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        ld_en,
  input  logic [3:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic [4:0]  psr,
  output logic        done,
  output logic        err
);

  seq_state_e  state_q, state_d;
  logic [4:0]  opcode_q;
  logic [3:0]  dest_q, src_q;
  logic [15:0] opA_q, opB_q, result_q;
  logic [4:0]  flags_q, psr_q;
  logic        done_q, done_d, err_q, err_d;
  logic        accept, illegal, psrWe;
  logic        rfWe;
  logic [3:0]  rfWaddr;
  logic [15:0] rfWdata;
  logic [15:0] rdA, rdB;
  logic [15:0] aluOut;
  logic [4:0]  aluFlags;
  logic [2:0]  unusedInstrBits;

  assign unusedInstrBits = instr[2:0];
  assign accept          = (state_q == ST_IDLE) && instr_valid;
  assign illegal         = (int'(opcode_q) >= NUM_OPS);

  regfile16 uRegfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (rfWe),
    .waddr_i   (rfWaddr),
    .wdata_i   (rfWdata),
    .raddrA_i  (src_q),
    .rdataA_o  (rdA),
    .raddrB_i  (dest_q),
    .rdataB_o  (rdB),
    .dbgAddr_i (dbg_addr),
    .dbgData_o (dbg_data)
  );

  ALU uAlu (
    .Rsrc   (opA_q),
    .Rdest  (opB_q),
    .OpCode (opcode_q),
    .Out    (aluOut),
    .Flags  (aluFlags)
  );

  // Control state, flag register and retirement pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      psr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (psrWe) begin
        psr_q <= flags_q;
      end
    end
  end

  // Datapath registers: instruction fields on accept, operands in READ, ALU result in EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q <= '0;
      dest_q   <= '0;
      src_q    <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (accept) begin
        opcode_q <= instrOpcode(instr);
        dest_q   <= instrDest(instr);
        src_q    <= instrSrc(instr);
      end
      if (state_q == ST_READ) begin
        opA_q <= rdA;
        opB_q <= rdB;
      end
      if (state_q == ST_EXEC) begin
        result_q <= aluOut;
        flags_q  <= aluFlags;
      end
    end
  end

  // Next state, register-file write port steering and write-back decisions
  always_comb begin
    state_d = state_q;
    rfWe    = 1'b0;
    rfWaddr = ld_addr;
    rfWdata = ld_data;
    psrWe   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d = ST_READ;
        end else if (ld_en) begin
          rfWe = 1'b1;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WRITE;
      ST_WRITE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        rfWaddr = dest_q;
        rfWdata = result_q;
        if (illegal) begin
          err_d = 1'b1;
        end else begin
          case (opcode_q)
            OP_ADD, OP_SUB: begin
              rfWe  = 1'b1;
              psrWe = 1'b1;
            end
            OP_CMP:  psrWe = 1'b1;
            default: rfWe = 1'b1;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign psr         = psr_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table of directed instructions,
// back-to-back issue, reset during execution and a randomised opcode sweep.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [4:0]  psr;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [4:0] modelPsr;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [15:0] dval;
    logic [15:0] sval;
    logic [15:0] expDst;
    logic        psrWr;
    logic [4:0]  expPsr;
    logic        expErr;
    string       name;
  } vec_t;

  vec_t vecs[17];

  alu_sequencer #(.NUM_OPS(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .psr         (psr),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadReg(input logic [3:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk); #1;
    ld_en   = 1'b0;
  endtask

  task automatic peekReg(input logic [3:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Issue one instruction and count edges from accept to the done cycle
  task automatic applyStimulus(input logic [4:0] op, input logic [3:0] dst, input logic [3:0] src,
                               output int lat, output logic sawErr);
    instr       = {op, dst, src, 3'b000};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    lat    = 0;
    sawErr = 1'b0;
    while (lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        sawErr = err;
        break;
      end
    end
  endtask

  function automatic void modelAlu(input logic [4:0] op, input logic [15:0] d, input logic [15:0] s,
                                   output logic [15:0] out, output logic wr, output logic psrWr,
                                   output logic [4:0] fl);
    int unsigned ud;
    int unsigned us;
    int sd;
    int ss;
    int sr;
    logic [3:0] sh;
    ud = d;
    us = s;
    sd = $signed(d);
    ss = $signed(s);
    sh = s[3:0];
    fl = '0;
    wr = 1'b1;
    psrWr = 1'b0;
    out = d;
    case (op)
      5'd0: begin
        out = 16'(ud + us);
        fl[FLAG_C] = (ud + us) > 65535;
        sr = sd + ss;
        fl[FLAG_F] = (sr > 32767) || (sr < -32768);
        psrWr = 1'b1;
      end
      5'd1: begin
        out = 16'(ud - us);
        fl[FLAG_C] = ud < us;
        sr = sd - ss;
        fl[FLAG_F] = (sr > 32767) || (sr < -32768);
        psrWr = 1'b1;
      end
      5'd2: begin
        wr = 1'b0;
        psrWr = 1'b1;
        fl[FLAG_Z] = (d == s);
        fl[FLAG_L] = ud < us;
        fl[FLAG_N] = sd < ss;
      end
      5'd3: out = d & s;
      5'd4: out = d | s;
      5'd5: out = d ^ s;
      5'd6: out = ~s;
      5'd7: out = 16'(ud << sh);
      5'd8: out = 16'(ud >> sh);
      5'd9: out = 16'(sd >>> sh);
      default: wr = 1'b0;
    endcase
  endfunction

  initial begin
    int lat;
    logic sawErr;
    logic [15:0] v;
    int doneAt[$];
    logic sawDone;

    vecs[0]  = '{OP_ADD,  4'd2,  4'd1,  16'h0001, 16'h7FFF, 16'h8000, 1'b1, 5'b00100, 1'b0, "add overflow"};
    vecs[1]  = '{OP_ADD,  4'd3,  4'd4,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 5'b10000, 1'b0, "add carry"};
    vecs[2]  = '{OP_SUB,  4'd6,  4'd7,  16'h0005, 16'h0007, 16'hFFFE, 1'b1, 5'b10000, 1'b0, "sub borrow"};
    vecs[3]  = '{OP_SUB,  4'd8,  4'd9,  16'h8000, 16'h0001, 16'h7FFF, 1'b1, 5'b00100, 1'b0, "sub overflow"};
    vecs[4]  = '{OP_ADD,  4'd6,  4'd6,  16'h1234, 16'h1234, 16'h2468, 1'b1, 5'b00000, 1'b0, "add dst==src"};
    vecs[5]  = '{OP_CMP,  4'd3,  4'd4,  16'h0005, 16'h0005, 16'h0005, 1'b1, 5'b00010, 1'b0, "cmp equal"};
    vecs[6]  = '{OP_AND,  4'd3,  4'd4,  16'h0005, 16'h0005, 16'h0005, 1'b0, 5'b00000, 1'b0, "and keeps psr"};
    vecs[7]  = '{OP_CMP,  4'd10, 4'd11, 16'h0001, 16'hFFFF, 16'h0001, 1'b1, 5'b01000, 1'b0, "cmp unsigned lt"};
    vecs[8]  = '{OP_CMP,  4'd11, 4'd10, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b1, 5'b00001, 1'b0, "cmp signed lt"};
    vecs[9]  = '{OP_OR,   4'd12, 4'd13, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 5'b00000, 1'b0, "or"};
    vecs[10] = '{OP_XOR,  4'd14, 4'd15, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 5'b00000, 1'b0, "xor"};
    vecs[11] = '{OP_NOT,  4'd0,  4'd1,  16'h0000, 16'h1234, 16'hEDCB, 1'b0, 5'b00000, 1'b0, "not into r0"};
    vecs[12] = '{OP_LSH,  4'd1,  4'd0,  16'h0003, 16'h0004, 16'h0030, 1'b0, 5'b00000, 1'b0, "lsh"};
    vecs[13] = '{OP_RSH,  4'd2,  4'd3,  16'h8000, 16'h000F, 16'h0001, 1'b0, 5'b00000, 1'b0, "rsh by 15"};
    vecs[14] = '{OP_ARSH, 4'd4,  4'd5,  16'h8000, 16'h0004, 16'hF800, 1'b0, 5'b00000, 1'b0, "arsh"};
    vecs[15] = '{5'h1F,   4'd7,  4'd8,  16'hABCD, 16'h1111, 16'hABCD, 1'b0, 5'b00000, 1'b1, "illegal 0x1F"};
    vecs[16] = '{5'd10,   4'd9,  4'd10, 16'h0F0F, 16'hF0F0, 16'h0F0F, 1'b0, 5'b00000, 1'b1, "illegal NUM_OPS"};

    reset       = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    dbg_addr    = '0;
    modelPsr    = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ready", 32'(instr_ready), 32'd1);
    checkOutput("reset psr", 32'(psr), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) begin
      peekReg(4'(a), v);
      checkOutput($sformatf("reset r%0d", a), 32'(v), 32'd0);
    end
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 17; i++) begin
      loadReg(vecs[i].src, vecs[i].sval);
      loadReg(vecs[i].dst, vecs[i].dval);
      applyStimulus(vecs[i].op, vecs[i].dst, vecs[i].src, lat, sawErr);
      if (vecs[i].psrWr) modelPsr = vecs[i].expPsr;
      checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'd3);
      checkOutput({vecs[i].name, " err"}, 32'(sawErr), 32'(vecs[i].expErr));
      checkOutput({vecs[i].name, " psr"}, 32'(psr), 32'(modelPsr));
      peekReg(vecs[i].dst, v);
      checkOutput({vecs[i].name, " dest"}, 32'(v), 32'(vecs[i].expDst));
      if (vecs[i].dst != vecs[i].src) begin
        peekReg(vecs[i].src, v);
        checkOutput({vecs[i].name, " src kept"}, 32'(v), 32'(vecs[i].sval));
      end
      @(posedge clk); #1;
      checkOutput({vecs[i].name, " done pulse"}, 32'(done), 32'd0);
    end

    $display("[TB] back-to-back ADD r5,r5 with ld_en during EXEC");
    loadReg(4'd5, 16'h0001);
    instr       = {OP_ADD, 4'd5, 4'd5, 3'b000};
    instr_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (done) doneAt.push_back(c);
      if (c == 1) begin
        checkOutput("b2b busy", 32'(instr_ready), 32'd0);
        ld_en   = 1'b1;
        ld_addr = 4'd5;
        ld_data = 16'hDEAD;
      end
      if (c == 2) ld_en = 1'b0;
      if (c == 8) instr_valid = 1'b0;
    end
    checkOutput("b2b done count", 32'(doneAt.size()), 32'd3);
    if (doneAt.size() == 3) begin
      checkOutput("b2b done 1", 32'(doneAt[0]), 32'd3);
      checkOutput("b2b done 2", 32'(doneAt[1]), 32'd7);
      checkOutput("b2b done 3", 32'(doneAt[2]), 32'd11);
    end
    peekReg(4'd5, v);
    checkOutput("b2b r5", 32'(v), 32'h8);
    modelPsr = 5'b00000;
    checkOutput("b2b psr", 32'(psr), 32'(modelPsr));
    @(posedge clk); #1;

    $display("[TB] random sweep over legal opcodes");
    for (int op = 0; op < 10; op++) begin
      for (int k = 0; k < 2; k++) begin
        logic [3:0]  dst, src;
        logic [15:0] d, s, out;
        logic        wr, pw;
        logic [4:0]  fl;
        dst = 4'($urandom_range(0, 15));
        src = 4'($urandom_range(0, 15));
        d   = 16'($urandom);
        s   = 16'($urandom);
        if (dst == src) s = d;
        loadReg(src, s);
        loadReg(dst, d);
        modelAlu(5'(op), d, s, out, wr, pw, fl);
        if (pw) modelPsr = fl;
        applyStimulus(5'(op), dst, src, lat, sawErr);
        checkOutput($sformatf("sweep op%0d latency", op), 32'(lat), 32'd3);
        checkOutput($sformatf("sweep op%0d err", op), 32'(sawErr), 32'd0);
        checkOutput($sformatf("sweep op%0d psr", op), 32'(psr), 32'(modelPsr));
        peekReg(dst, v);
        checkOutput($sformatf("sweep op%0d dest", op), 32'(v), 32'(wr ? out : d));
        @(posedge clk); #1;
      end
    end

    $display("[TB] reset during EXEC");
    loadReg(4'd1, 16'h0007);
    loadReg(4'd2, 16'h0009);
    loadReg(4'd3, 16'hFFFF);
    loadReg(4'd4, 16'h0001);
    applyStimulus(OP_SUB, 4'd4, 4'd3, lat, sawErr);
    checkOutput("pre-reset psr", 32'(psr), 32'b10000);
    @(posedge clk); #1;
    instr       = {OP_ADD, 4'd2, 4'd1, 3'b000};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("exec busy", 32'(instr_ready), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("mid reset ready", 32'(instr_ready), 32'd1);
    checkOutput("mid reset psr", 32'(psr), 32'd0);
    checkOutput("mid reset done", 32'(done), 32'd0);
    for (int a = 0; a < 16; a++) begin
      peekReg(4'(a), v);
      checkOutput($sformatf("mid reset r%0d", a), 32'(v), 32'd0);
    end
    #3;
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      sawDone = sawDone | done;
    end
    checkOutput("no done after reset", 32'(sawDone), 32'd0);
    peekReg(4'd2, v);
    checkOutput("write discarded", 32'(v), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
